vec_wb_collect: RTL

- Writeback-side collector directly downstream of the 4-lane ALU execute stage.
- Vector ops issue over 1-4 beats: each beat carries one 16-bit result per lane. This block reassembles the beats into a single 256-bit vector register write.
- Scalar results pass through to the scalar register file write port.
- Sits between the lane outputs of execute 2 and the write ports of the scalar and vector register files.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/vec_lane_merge.sv | 35 +++
 rtl/vec_wb_collect.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Lane/vector geometry and beat helpers shared by execute and
//           writeback stages.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int LANES      = 4;
    localparam int ELEM_W     = 16;
    localparam int MAX_ELEMS  = 16;
    localparam int VEC_W      = MAX_ELEMS * ELEM_W;
    localparam int LANE_BUS_W = LANES * ELEM_W;
    localparam int MAX_BEATS  = MAX_ELEMS / LANES;

    typedef logic [1:0] beat_t;
    typedef logic [4:0] len_t;

    // LSB offset of element 4*beat+lane; element 0 occupies the MSBs.
    function automatic logic [7:0] elem_slice(input beat_t beat, input logic [1:0] lane);
        logic [3:0] e;
        e = {beat, lane};
        return 8'd240 - {e, 4'b0000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_lane_merge.sv
// ============================================================================
// Module  : vec_lane_merge
// Brief   : Combinational merge of one beat of lane results into the vector
//           accumulator, zeroing elements at or beyond the vector length.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module vec_lane_merge
    import cpu_pkg::*;
(
    input  logic [VEC_W-1:0]      acc_in,
    input  beat_t                 beat,
    input  len_t                  len,
    input  logic [LANE_BUS_W-1:0] lanes,
    output logic [VEC_W-1:0]      acc_out
);

    for (genvar b = 0; b < MAX_BEATS; b++) begin : g_beat
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            localparam int         c_elem = b * LANES + k;
            localparam logic [7:0] c_off  = elem_slice(beat_t'(b), 2'(k));

            logic w_keep;
            assign w_keep = (len > len_t'(c_elem));

            assign acc_out[c_off +: ELEM_W] = (beat == beat_t'(b))
                ? (w_keep ? lanes[k*ELEM_W +: ELEM_W] : '0)
                : acc_in[c_off +: ELEM_W];
        end
    end

endmodule

`default_nettype wire

// File: rtl/vec_wb_collect.sv
// ============================================================================
// Module  : vec_wb_collect
// Brief   : Writeback collector; reassembles 1-4 lane beats into a 256-bit
//           vector register write and passes scalar results through.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module vec_wb_collect
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_vector,
    input  logic                  in_wen,
    input  logic [1:0]            in_beat,
    input  logic [4:0]            in_len,
    input  logic [3:0]            in_rt,
    input  logic [LANE_BUS_W-1:0] in_lanes,
    output logic                  reg_wen,
    output logic [3:0]            reg_waddr,
    output logic [ELEM_W-1:0]     reg_wdata,
    output logic                  vreg_wen,
    output logic [3:0]            vreg_waddr,
    output logic [VEC_W-1:0]      vreg_wdata,
    output logic [4:0]            vreg_wlen,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    beat_t             exp_q, exp_d;
    logic [VEC_W-1:0]  acc_q, acc_d;
    logic [3:0]        rt_q, rt_d;
    len_t              len_q, len_d;

    logic              reg_wen_q, reg_wen_d;
    logic [3:0]        reg_waddr_q, reg_waddr_d;
    logic [ELEM_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              vreg_wen_q, vreg_wen_d;
    logic [3:0]        vreg_waddr_q, vreg_waddr_d;
    logic [VEC_W-1:0]  vreg_wdata_q, vreg_wdata_d;
    len_t              vreg_wlen_q, vreg_wlen_d;
    logic              err_q, err_d;

    logic              w_start;
    logic [2:0]        w_nb_in;
    logic [2:0]        w_nb_q;
    logic [VEC_W-1:0]  w_merge_base;
    len_t              w_merge_len;
    logic [VEC_W-1:0]  w_merged;

    // Any beat 0 starts a new vector; in COLLECT the expected beat is never 0,
    // so this also covers the restart-after-violation case.
    assign w_start = in_valid && in_vector && in_wen && (in_beat == 2'd0) && (in_len != 5'd0);

    assign w_nb_in      = 3'((in_len + 5'd3) >> 2);
    assign w_nb_q       = 3'((len_q + 5'd3) >> 2);
    assign w_merge_base = w_start ? '0 : acc_q;
    assign w_merge_len  = w_start ? in_len : len_q;

    vec_lane_merge u_merge (
        .acc_in  (w_merge_base),
        .beat    (in_beat),
        .len     (w_merge_len),
        .lanes   (in_lanes),
        .acc_out (w_merged)
    );

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        acc_d        = acc_q;
        rt_d         = rt_q;
        len_d        = len_q;
        reg_wen_d    = 1'b0;
        reg_waddr_d  = '0;
        reg_wdata_d  = '0;
        vreg_wen_d   = 1'b0;
        vreg_waddr_d = '0;
        vreg_wdata_d = '0;
        vreg_wlen_d  = '0;
        err_d        = 1'b0;

        if (flush) begin
            state_d = IDLE;
            exp_d   = '0;
            acc_d   = '0;
        end else if (in_valid) begin
            if (state_q == COLLECT) begin
                if (in_vector && (in_beat == exp_q)) begin
                    acc_d = w_merged;
                    if ({1'b0, in_beat} == (w_nb_q - 3'd1)) begin
                        vreg_wen_d   = 1'b1;
                        vreg_waddr_d = rt_q;
                        vreg_wdata_d = w_merged;
                        vreg_wlen_d  = len_q;
                        state_d      = IDLE;
                        exp_d        = '0;
                    end else begin
                        exp_d = exp_q + 2'd1;
                    end
                end else begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    state_d = IDLE;
                    exp_d   = '0;
                end
            end else if (!in_vector && in_wen) begin
                reg_wen_d   = 1'b1;
                reg_waddr_d = in_rt;
                reg_wdata_d = in_lanes[ELEM_W-1:0];
            end

            if (w_start) begin
                acc_d = w_merged;
                rt_d  = in_rt;
                len_d = in_len;
                if (w_nb_in == 3'd1) begin
                    vreg_wen_d   = 1'b1;
                    vreg_waddr_d = in_rt;
                    vreg_wdata_d = w_merged;
                    vreg_wlen_d  = in_len;
                    state_d      = IDLE;
                    exp_d        = '0;
                end else begin
                    state_d = COLLECT;
                    exp_d   = 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            acc_q        <= '0;
            rt_q         <= '0;
            len_q        <= '0;
            reg_wen_q    <= 1'b0;
            reg_waddr_q  <= '0;
            reg_wdata_q  <= '0;
            vreg_wen_q   <= 1'b0;
            vreg_waddr_q <= '0;
            vreg_wdata_q <= '0;
            vreg_wlen_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            acc_q        <= acc_d;
            rt_q         <= rt_d;
            len_q        <= len_d;
            reg_wen_q    <= reg_wen_d;
            reg_waddr_q  <= reg_waddr_d;
            reg_wdata_q  <= reg_wdata_d;
            vreg_wen_q   <= vreg_wen_d;
            vreg_waddr_q <= vreg_waddr_d;
            vreg_wdata_q <= vreg_wdata_d;
            vreg_wlen_q  <= vreg_wlen_d;
            err_q        <= err_d;
        end
    end

    assign reg_wen    = reg_wen_q;
    assign reg_waddr  = reg_waddr_q;
    assign reg_wdata  = reg_wdata_q;
    assign vreg_wen   = vreg_wen_q;
    assign vreg_waddr = vreg_waddr_q;
    assign vreg_wdata = vreg_wdata_q;
    assign vreg_wlen  = vreg_wlen_q;
    assign err        = err_q;
    assign busy       = (state_q == COLLECT);

endmodule

`default_nettype wire
